// File: rtl/spi_regs_pkg.sv
// Shared types and frame constants for the SPI register-file responder.
package spi_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DAT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned HDR_BITS = 16;
    localparam int unsigned DAT_BITS = 8;
    localparam int unsigned FRM_BITS = HDR_BITS + DAT_BITS;
    localparam int unsigned RW_BIT   = 15;

endpackage

// File: rtl/spi_pin_sync.sv
// 2-FF synchronisers for CS/SCLK/MOSI plus a registered edge detector.
// Edge flags and the sampled MOSI bit are aligned to the same cycle.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi
);

    logic [1:0] cs_s;
    logic [1:0] sclk_s;
    logic [1:0] mosi_s;
    logic       cs_q;
    logic       sclk_q;

    // CS sync resets low so a CS already low at reset release never looks like a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s      <= 2'b00;
            sclk_s    <= 2'b11;
            mosi_s    <= 2'b00;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b1;
            cs_n      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            cs_s      <= {cs_s[0], cs_i};
            sclk_s    <= {sclk_s[0], sclk_i};
            mosi_s    <= {mosi_s[0], mosi_i};
            cs_q      <= cs_s[1];
            sclk_q    <= sclk_s[1];
            cs_n      <= cs_s[1];
            sclk_rise <= sclk_s[1] & ~sclk_q;
            sclk_fall <= ~sclk_s[1] & sclk_q;
            cs_fall   <= ~cs_s[1] & cs_q;
            cs_rise   <= cs_s[1] & ~cs_q;
            mosi      <= mosi_s[1];
        end
    end

endmodule

// File: rtl/spi_regs_slave.sv
// SPI responder serving 24-bit read/write frames into an 8-bit register file.
// Optional abort counter built only when SPI_REGS_SLAVE_ERR_CNT_EN is defined.
module spi_regs_slave
    import spi_regs_pkg::*;
#(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              spi_cs_i,
    input  logic              spi_clk_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [8*NREG-1:0] reg_o,
    output logic              wr_stb_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [7:0]        err_cnt_o
);

    logic cs_n, sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;

    spi_pin_sync u_sync (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .cs_i      (spi_cs_i),
        .sclk_i    (spi_clk_i),
        .mosi_i    (spi_mosi_i),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi      (mosi)
    );

    state_e        state;
    logic [4:0]    bit_cnt;
    logic [14:0]   sh;
    logic          rw;
    logic          in_range;
    logic [AW-1:0] addr;
    logic [7:0]    rd_shift;
    logic [7:0]    regs [NREG];

    logic [15:0] hdr_c;
    logic [7:0]  dat_c;
    logic        hdr_in_range_c;
    logic        last_rise_c;
    logic        abort_c;

    assign hdr_c          = {sh, mosi};
    assign dat_c          = {sh[6:0], mosi};
    assign hdr_in_range_c = (hdr_c[14:AW] == '0);
    assign last_rise_c    = sclk_rise && (bit_cnt == 5'(FRM_BITS - 1));
    // A CS rise coinciding with the final SCLK rise lets the frame complete.
    assign abort_c        = cs_rise && ((state == ST_HDR) ||
                                        ((state == ST_DAT) && !last_rise_c));

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign reg_o[8*k +: 8] = regs[k];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            sh            <= '0;
            rw            <= 1'b0;
            in_range      <= 1'b0;
            addr          <= '0;
            rd_shift      <= '0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            wr_stb_o      <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            if (abort_c) begin
                state         <= ST_IDLE;
                spi_miso_o    <= 1'b0;
                spi_miso_oe_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_HDR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise) begin
                            sh      <= hdr_c[14:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(HDR_BITS - 1)) begin
                                rw            <= hdr_c[RW_BIT];
                                addr          <= hdr_c[AW-1:0];
                                in_range      <= hdr_in_range_c;
                                rd_shift      <= hdr_in_range_c ? regs[hdr_c[AW-1:0]] : 8'h00;
                                spi_miso_oe_o <= hdr_c[RW_BIT];
                                state         <= ST_DAT;
                            end
                        end
                    end
                    ST_DAT: begin
                        if (sclk_fall && rw) begin
                            spi_miso_o <= rd_shift[7];
                            rd_shift   <= {rd_shift[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            sh      <= hdr_c[14:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(FRM_BITS - 1)) begin
                                if (!rw && in_range) begin
                                    regs[addr] <= dat_c;
                                    wr_stb_o   <= 1'b1;
                                    wr_addr_o  <= addr;
                                    wr_data_o  <= dat_c;
                                end
                                spi_miso_o    <= 1'b0;
                                spi_miso_oe_o <= 1'b0;
                                state         <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (cs_n) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_REGS_SLAVE_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Saturating count of aborted frames.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt <= '0;
        end else if (abort_c && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_regs_slave.sv
// Scoreboard bench for spi_regs_slave: stimulus pushes expected writes and
// per-frame MISO/OE expectations; independent monitors pop and compare.
module tb_spi_regs_slave;

    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
    localparam int          HALF = 8;
`ifdef SPI_REGS_SLAVE_ERR_CNT_EN
    localparam logic [7:0] EXP_ERR = 8'd1;
`else
    localparam logic [7:0] EXP_ERR = 8'd0;
`endif

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              spi_cs_i = 1'b1;
    logic              spi_clk_i = 1'b1;
    logic              spi_mosi_i = 1'b0;
    logic              spi_miso_o;
    logic              spi_miso_oe_o;
    logic [8*NREG-1:0] reg_o;
    logic              wr_stb_o;
    logic [AW-1:0]     wr_addr_o;
    logic [7:0]        wr_data_o;
    logic [7:0]        err_cnt_o;

    spi_regs_slave #(.NREG(NREG), .AW(AW)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .spi_cs_i      (spi_cs_i),
        .spi_clk_i     (spi_clk_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .reg_o         (reg_o),
        .wr_stb_o      (wr_stb_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [23:0] oe_mask;
        logic [7:0]  rd;
    } frm_t;

    wr_t        exp_wr [$];
    frm_t       exp_frm [$];
    logic [7:0] model [NREG];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk_reset_vals();
        chk("rst_reg_o_zero", 32'(reg_o != '0), 32'd0);
        chk("rst_wr_stb", 32'(wr_stb_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("rst_miso", 32'(spi_miso_o), 32'd0);
        chk("rst_miso_oe", 32'(spi_miso_oe_o), 32'd0);
    endtask

    // Drives one frame; bits past 24 send 1s, rst_at >= 0 pulses reset after that bit's low half.
    task automatic spi_frame(input logic [23:0] word, input int nbits, input int rst_at);
        spi_cs_i = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            spi_clk_i  = 1'b0;
            spi_mosi_i = (i < 24) ? word[23-i] : 1'b1;
            wait_clk(HALF);
            if (i == rst_at) begin
                rstn_i = 1'b0;
                wait_clk(2);
                chk_reset_vals();
                rstn_i = 1'b1;
                for (int k = 0; k < NREG; k++) model[k] = 8'h00;
            end
            spi_clk_i = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(6);
        spi_cs_i = 1'b1;
        wait_clk(8);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [7:0] d, input int nbits, input bit commits);
        frm_t f;
        wr_t  w;
        f.oe_mask = 24'h0;
        f.rd      = 8'h00;
        exp_frm.push_back(f);
        if (commits) begin
            w.addr = a[3:0];
            w.data = d;
            exp_wr.push_back(w);
            model[a[3:0]] = d;
        end
        spi_frame({1'b0, a, d}, nbits, -1);
    endtask

    task automatic do_read(input logic [14:0] a, input logic [7:0] exp_d);
        frm_t f;
        f.oe_mask = 24'h0000FF;
        f.rd      = exp_d;
        exp_frm.push_back(f);
        spi_frame({1'b1, a, 8'h00}, 24, -1);
    endtask

    // Write-commit monitor.
    always @(negedge clk_i) begin
        if (rstn_i && wr_stb_o === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
                chk("wr_data", 32'(wr_data_o), 32'(e.data));
                chk("wr_reg_o", 32'(reg_o[8*int'(e.addr) +: 8]), 32'(e.data));
            end
        end
    end

    // Frame monitor: OE sampled at every SCLK rise, MISO collected on rises 17..24.
    logic        cs_prev = 1'b1;
    int          mon_idx = 0;
    logic [23:0] mon_mask = '0;
    logic [7:0]  mon_byte = '0;

    always @(posedge spi_clk_i or posedge spi_cs_i or negedge spi_cs_i) begin
        if (spi_cs_i !== cs_prev) begin
            cs_prev = spi_cs_i;
            if (spi_cs_i === 1'b0) begin
                mon_idx  = 0;
                mon_mask = '0;
                mon_byte = '0;
            end else if (exp_frm.size() == 0) begin
                chk("frame_unexpected", 32'd1, 32'd0);
            end else begin
                frm_t f;
                f = exp_frm.pop_front();
                chk("frame_oe_window", 32'(mon_mask), 32'(f.oe_mask));
                chk("frame_miso_byte", 32'(mon_byte), 32'(f.rd));
            end
        end else if (spi_cs_i === 1'b0) begin
            if (mon_idx < 24) begin
                mon_mask[23-mon_idx] = spi_miso_oe_o;
                if (mon_idx >= 16) mon_byte = {mon_byte[6:0], spi_miso_o};
            end
            mon_idx++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NREG; k++) model[k] = 8'h00;
        wait_clk(3);
        chk_reset_vals();
        rstn_i = 1'b1;
        wait_clk(6);

        do_write(15'h0005, 8'hA7, 24, 1'b1);
        do_read (15'h0005, 8'hA7);
        do_write(15'h0013, 8'h55, 24, 1'b0);
        chk("oor_reg3_untouched", 32'(reg_o[8*3 +: 8]), 32'h00);
        do_read (15'h0013, 8'h00);
        do_write(15'h0003, 8'h3C, 24, 1'b1);
        do_write(15'h0003, 8'h99, 20, 1'b0);
        chk("abort_reg3", 32'(reg_o[8*3 +: 8]), 32'h3C);
        chk("abort_err_cnt", 32'(err_cnt_o), 32'(EXP_ERR));
        do_write(15'h000F, 8'h5A, 30, 1'b1);
        do_read (15'h000F, 8'h5A);
        do_read (15'h0003, 8'h3C);
        do_write(15'h0000, 8'h81, 24, 1'b1);
        do_read (15'h0000, 8'h81);

        // Reset mid-header: the rest of that frame must be ignored.
        begin
            frm_t f;
            f.oe_mask = 24'h0;
            f.rd      = 8'h00;
            exp_frm.push_back(f);
            spi_frame({1'b0, 15'h0002, 8'h11}, 24, 8);
        end
        chk("post_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        do_write(15'h0002, 8'hC3, 24, 1'b1);
        do_read (15'h0002, 8'hC3);
        do_read (15'h0005, 8'h00);

        wait_clk(10);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("frame_queue_empty", 32'(exp_frm.size()), 32'd0);
        for (int k = 0; k < NREG; k++) chk("final_reg", 32'(reg_o[8*k +: 8]), 32'(model[k]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
